// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS IF stage - owns the PC, fetches from imem and fills the IF/ID register
// Ports: clk/rst (async active-low) | imem_pc_o -> imem, imem_instr <- imem (same cycle)
//        stall/flush/redirect/redirect_pc from hazard and branch logic
//        if_id_instr/if_id_pc4/if_id_valid to decode | halted, misalign_err status
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err
);
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic        legal;
  logic [31:0] pc_plus4;
  assign legal    = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);
  assign pc_plus4 = pc_q + 32'd4;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect) begin
          valid_d = 1'b0;
          if (legal) pc_d = redirect_pc;
          else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end else if (stall) begin
          valid_d = flush ? 1'b0 : valid_q;
        end else begin
          instr_d = imem_instr;
          pc4_d   = pc_plus4;
          valid_d = ~flush;
          // the last word is still delivered; the PC parks on it so it never wraps
          if (pc_q == LAST_PC) state_d = HALT;
          else pc_d = pc_plus4;
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (redirect) begin
          if (legal) begin
            pc_d    = redirect_pc;
            state_d = RUN;
          end else err_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end
  assign imem_pc      = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign halted       = (state_q == HALT);
  assign misalign_err = err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus randomized check of instr_fetch_unit against a reference model
module tb_instr_fetch_unit;
  localparam int MEM_BYTES = 512;
  localparam int LAST = MEM_BYTES - 4;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_pc, imem_instr, redirect_pc, if_id_instr, if_id_pc4;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic        if_id_valid, halted, misalign_err;
  logic [31:0] mem [MEM_BYTES/4];
  int checks = 0;
  int errors = 0;
  int          m_state;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_err;
  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .halted(halted), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  assign imem_instr = (imem_pc < MEM_BYTES) ? mem[imem_pc[8:2]] : 32'hDEAD_BEEF;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, " pc"}, imem_pc, m_pc);
    chk({tag, " instr"}, if_id_instr, m_instr);
    chk({tag, " pc4"}, if_id_pc4, m_pc4);
    chk({tag, " valid"}, 32'(if_id_valid), 32'(m_valid));
    chk({tag, " halted"}, 32'(halted), 32'(m_state == 2));
    chk({tag, " err"}, 32'(misalign_err), 32'(m_err));
  endtask
  function automatic bit is_legal(input logic [31:0] a);
    return a % 4 == 0 && a <= LAST;
  endfunction
  task automatic model_reset();
    m_state = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_err = 0;
  endtask
  // Reference behaviour of one rising edge, from the stage's rules.
  task automatic model_edge(input bit st, input bit fl, input bit rd, input logic [31:0] rpc);
    if (m_state == 0) m_state = 1;
    else if (m_state == 1) begin
      if (rd) begin
        m_valid = 0;
        if (is_legal(rpc)) m_pc = rpc;
        else begin m_err = 1; m_state = 2; end
      end else if (st) begin
        if (fl) m_valid = 0;
      end else begin
        m_instr = mem[m_pc / 4];
        m_pc4 = m_pc + 4;
        m_valid = !fl;
        if (m_pc == LAST) m_state = 2;
        else m_pc = m_pc + 4;
      end
    end else begin
      m_valid = 0;
      if (rd) begin
        if (is_legal(rpc)) begin m_pc = rpc; m_state = 1; end
        else m_err = 1;
      end
    end
  endtask
  task automatic cyc(input string tag, input bit st, input bit fl, input bit rd, input logic [31:0] rpc);
    stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
    model_edge(st, fl, rd, rpc);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  task automatic async_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < MEM_BYTES / 4; i++) mem[i] = $urandom;
    mem[0] = 32'h2401_0005;
    mem[1] = 32'h241F_0000;
    mem[8] = 32'h2442_0002;
    redirect_pc = 0;
    model_reset();
    #2;
    check_all("reset");
    #6 rst = 1'b1;
    cyc("boot", 0, 0, 1, 32'h40);
    cyc("e1", 0, 0, 0, 0);
    cyc("e2", 0, 0, 0, 0);
    cyc("stall1", 1, 0, 0, 0);
    cyc("stall2", 1, 0, 0, 0);
    cyc("stallflush", 1, 1, 0, 0);
    cyc("release", 0, 0, 0, 0);
    cyc("redir_stall", 1, 0, 1, 32'h20);
    cyc("redir_target", 0, 0, 0, 0);
    cyc("to_last", 0, 0, 1, 32'h1FC);
    cyc("last_word", 0, 0, 0, 0);
    cyc("halt_hold", 1, 1, 0, 0);
    cyc("halt_to0", 0, 0, 1, 32'h0);
    cyc("illegal_22", 0, 0, 1, 32'h22);
    cyc("illegal_200", 0, 0, 1, 32'h200);
    cyc("resume_4", 0, 0, 1, 32'h4);
    cyc("run8", 0, 0, 0, 0);
    cyc("runC", 0, 0, 0, 0);
    cyc("run10", 0, 0, 0, 0);
    chk("pc_before_reset", imem_pc, 32'h10);
    async_reset("midrun_reset");
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] t;
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) t = $urandom;
      else if (r < 6) t = {$urandom_range(0, 127), 2'b00} + 32'($urandom_range(1, 3));
      else if (r < 8) t = 32'(LAST) + 32'($urandom_range(1, 8));
      else if (r < 12) t = 32'(LAST) - 32'(4 * $urandom_range(0, 3));
      else t = 32'({$urandom_range(0, 127), 2'b00});
      if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
      else cyc("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 19) == 0 || (m_state == 2 && $urandom_range(0, 2) == 0), t);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage of the single-issue MIPS pipeline. Owns the program counter and drives it as a byte address to the instruction memory. Samples the 32-bit big-endian word the memory returns combinationally, and registers it with PC+4 into the IF/ID pipeline register for the decoder. Handles stall, flush and branch/jump redirect, and halts cleanly at the memory boundary or on an illegal target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `MEM_BYTES`, default 512: instruction memory size in bytes; legal PCs are word-aligned and ≤ MEM_BYTES-4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_pc`  out  32  fetch address to instruction memory; equals the PC register (combinational from the register).
- `imem_instr`  in  32  instruction word returned by memory for `imem_pc`, valid in the same cycle.
- `stall`  in  1  hazard unit holds PC and IF/ID.
- `flush`  in  1  squash: the next IF/ID capture is a bubble.
- `redirect`  in  1  taken branch/jump; load `redirect_pc`.
- `redirect_pc`  in  32  branch/jump target byte address.
- `if_id_instr`  out  32  registered instruction.
- `if_id_pc4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction; 0 = bubble.
- `halted`  out  1  unit is in HALT.
- `misalign_err`  out  1  sticky; set by an illegal redirect target.

## Operation
- States: BOOT, RUN, HALT.
- Reset (rst=0, async): state=BOOT, pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0, misalign_err=0.
- BOOT: one cycle; no capture. Next state is RUN. A redirect seen in BOOT is ignored.
- RUN, per edge, in priority order:
  1. **redirect=1:** check `redirect_pc`. It is legal when [1:0]==0 and value ≤ MEM_BYTES-4.
     - Legal: pc<=redirect_pc, IF/ID<=bubble (valid=0, instr and pc4 hold). Applies even with stall=1.
     - Illegal: pc holds, IF/ID<=bubble, misalign_err<=1, state<=HALT.
  2. **stall=1:** pc holds.
     - IF/ID holds, unless flush=1, which clears valid only.
  3. **Normal:** pc<=pc+4.
     - IF/ID<={imem_instr, pc+4, ~flush}. When flush=1, instr and pc4 still load, but valid=0.
     - If the captured pc == MEM_BYTES-4: state<=HALT and pc holds. This final instruction is still delivered.
- HALT: halted=1, pc holds, if_id_valid<=0 every edge; stall and flush have no effect.
  - A legal redirect: pc<=redirect_pc, state<=RUN, halted<=0. misalign_err stays set.
  - An illegal redirect: stays in HALT.
- Arithmetic: pc+4 is 32-bit modulo. Wrap cannot occur, because the halt check precedes it.
- misalign_err clears only on reset.

## Timing
- `imem_pc` changes only after clock edges or an async reset; there is no combinational path from any input to it.
- Reset release to first valid IF/ID: reset deasserts before edge E0 (BOOT→RUN). Edge E1 captures the word at RESET_PC, so if_id_valid=1 after E1.
- Throughput: one instruction per cycle in RUN without stall.
- Redirect penalty: the redirect edge produces one bubble. The target instruction is valid after the following edge.
- `halted` rises on the edge that captures the last word. if_id_valid drops on the next edge.
- Reset asserted mid-operation: all outputs return to reset values immediately, with no clock edge needed.

## Test plan
- **Reset/boot:** memory word0=0x24010005, word1=0x241F0000. Release rst, then 3 edges. Expected: valid=0 after E0; after E1 instr=0x24010005, pc4=4; after E2 instr=0x241F0000, pc4=8.
- **Stall + flush:** hold stall=1 for 2 cycles at pc=8. Expected: pc stays 8 and IF/ID unchanged. Then stall=1, flush=1 for 1 cycle. Expected: valid=0 and pc still 8. Then release. Expected: next capture is pc4=12.
- **Redirect:** redirect=1, redirect_pc=0x20 (word 0x24420002) while stall=1. Expected: bubble, imem_pc=0x20. Next edge: instr=0x24420002, pc4=0x24.
- **Boundary:** redirect to 0x1FC, then run. Expected: word at 0x1FC captured with valid=1 and halted=1. Next edge: valid=0, pc stays 0x1FC. Redirect to 0x0. Expected: back to RUN, halted=0.
- **Illegal targets:** redirect_pc=0x22. Expected: misalign_err=1, halted=1, pc unchanged. Redirect_pc=0x200. Expected: stays halted. Redirect_pc=0x4. Expected: RUN resumes, misalign_err stays 1.
- **Async reset mid-run:** assert rst between edges at pc=0x10. Expected: immediately pc=0, valid=0, halted=0, misalign_err=0.
